// File: rtl/muldiv_controller.sv
// muldiv_controller: sequences one MULT or DIV operation from request to the
// HI/LO writeback, with a timeout on the arithmetic unit and a flush input.
module muldiv_controller #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_op,
  output logic        req_ready,
  input  logic        abort,
  output logic        mult_start,
  output logic        div_start,
  input  logic        mult_done,
  input  logic        div_done,
  input  logic [63:0] mult_result,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        div_by_zero,
  output logic [31:0] hi_in,
  output logic [31:0] lo_in,
  output logic        hi_write,
  output logic        lo_write,
  output logic        busy,
  output logic        done,
  output logic        div0_exc,
  output logic        timeout_exc
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    WB,
    TMO
  } state_e;

  state_e        state_q, state_d;
  logic          op_q, op_d;
  logic          dz_q, dz_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          sel_done;

  // The done flag of the unit not selected by op_q is never looked at.
  assign sel_done = op_q ? div_done : mult_done;

  // Next-state logic: accept, start, wait with timeout, latch results; abort flushes START/WAIT.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dz_d    = dz_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = abort ? IDLE : WAIT;
      end
      WAIT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (sel_done) begin
          if (op_q) begin
            hi_d = div_remainder;
            lo_d = div_quotient;
            dz_d = div_by_zero;
          end else begin
            hi_d = mult_result[63:32];
            lo_d = mult_result[31:0];
          end
          state_d = WB;
        end else if (cnt_q == CntLast) begin
          state_d = TMO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WB:      state_d = IDLE;
      TMO:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset outranks every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Moore outputs decoded from the state and the latched op/result registers only.
  always_comb begin
    busy        = (state_q != IDLE);
    req_ready   = (state_q == IDLE);
    mult_start  = 1'b0;
    div_start   = 1'b0;
    done        = 1'b0;
    hi_write    = 1'b0;
    lo_write    = 1'b0;
    div0_exc    = 1'b0;
    timeout_exc = 1'b0;
    hi_in       = hi_q;
    lo_in       = lo_q;
    case (state_q)
      START: begin
        mult_start = ~op_q;
        div_start  = op_q;
      end
      WB: begin
        done     = 1'b1;
        div0_exc = op_q & dz_q;
        hi_write = ~(op_q & dz_q);
        lo_write = ~(op_q & dz_q);
      end
      TMO:     timeout_exc = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_muldiv_controller.sv
// tb_muldiv_controller: randomized and directed checks of muldiv_controller
// against a transaction-level model of its cycle timing and writeback outcome.
module tb_muldiv_controller;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_op = 1'b0;
  logic        req_ready;
  logic        abort = 1'b0;
  logic        mult_start, div_start;
  logic        mult_done = 1'b0;
  logic        div_done = 1'b0;
  logic [63:0] mult_result = '0;
  logic [31:0] div_quotient = '0;
  logic [31:0] div_remainder = '0;
  logic        div_by_zero = 1'b0;
  logic [31:0] hi_in, lo_in;
  logic        hi_write, lo_write, busy, done, div0_exc, timeout_exc;

  int checks = 0;
  int passed = 0;

  // Observations gathered by runTxn; cycle 0 is the first cycle after acceptance.
  int          obsMultStarts, obsDivStarts, obsBothStarts;
  int          obsDone, obsDoneCyc, obsDiv0, obsTmo, obsTmoCyc;
  int          obsBadWrite, obsBadBusy, obsReadyCyc;
  logic [31:0] obsHi, obsLo;
  logic        obsWrAny, obsWrBoth;

  // Model predictions
  int          eReady, eDoneCyc, eTmoCyc;
  logic        eDiv0, eWrite;
  logic [31:0] eHi, eLo;

  always #5 clk = ~clk;

  muldiv_controller #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_ready(req_ready), .abort(abort), .mult_start(mult_start),
    .div_start(div_start), .mult_done(mult_done), .div_done(div_done),
    .mult_result(mult_result), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .div_by_zero(div_by_zero),
    .hi_in(hi_in), .lo_in(lo_in), .hi_write(hi_write), .lo_write(lo_write),
    .busy(busy), .done(done), .div0_exc(div0_exc), .timeout_exc(timeout_exc)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] x, y;
    x = $signed(a);
    y = $signed(b);
    return x * y;
  endfunction

  function automatic logic [72:0] idleVec();
    return {req_ready, busy, done, div0_exc, timeout_exc, mult_start, div_start,
            hi_write, lo_write, hi_in, lo_in};
  endfunction

  // Transaction-level model: the unit is occupied in cycles 0..lastBusy, where
  // cycle 0 is the start cycle and cycles 1..T are the allowed wait cycles.
  task automatic model(input logic op, input int doneCyc, input int abortCyc,
                       input logic [63:0] mres, input logic [31:0] q,
                       input logic [31:0] r, input logic dz);
    int lastBusy;
    bit doneInTime;
    doneInTime = (doneCyc >= 1) && (doneCyc <= T);
    lastBusy   = doneInTime ? doneCyc : T;
    eDoneCyc = -1; eTmoCyc = -1; eDiv0 = 1'b0; eWrite = 1'b0; eHi = '0; eLo = '0;
    if (abortCyc >= 0 && abortCyc <= lastBusy) begin
      eReady = abortCyc + 1;
    end else if (doneInTime) begin
      eDoneCyc = doneCyc + 1;
      eReady   = doneCyc + 2;
      if (op) begin
        eHi = r; eLo = q; eDiv0 = dz; eWrite = !dz;
      end else begin
        eHi = 32'(mres >> 32); eLo = 32'(mres); eWrite = 1'b1;
      end
    end else begin
      eTmoCyc = T + 1;
      eReady  = T + 2;
    end
  endtask

  // Issues one request and drives the units cycle by cycle until the controller is idle again.
  task automatic runTxn(input logic op, input int doneCyc, input int abortCyc,
                        input logic [63:0] mres, input logic [31:0] q,
                        input logic [31:0] r, input logic dz,
                        input bit noiseOther, input bit noiseReq);
    obsMultStarts = 0; obsDivStarts = 0; obsBothStarts = 0;
    obsDone = 0; obsDoneCyc = -1; obsDiv0 = 0; obsTmo = 0; obsTmoCyc = -1;
    obsBadWrite = 0; obsBadBusy = 0; obsReadyCyc = -1;
    obsHi = 'x; obsLo = 'x; obsWrAny = 1'b0; obsWrBoth = 1'b0;
    mult_result = mres; div_quotient = q; div_remainder = r; div_by_zero = dz;
    req_valid = 1'b1; req_op = op;
    tick;
    req_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0 && req_ready === 1'b1) begin
        obsReadyCyc = c;
        break;
      end
      if (busy !== ~req_ready) obsBadBusy++;
      if (mult_start) obsMultStarts++;
      if (div_start) obsDivStarts++;
      if (mult_start && div_start) obsBothStarts++;
      if (done) begin
        obsDone++; obsDoneCyc = c; obsHi = hi_in; obsLo = lo_in;
        obsWrAny = hi_write | lo_write; obsWrBoth = hi_write & lo_write;
      end else if (hi_write || lo_write) begin
        obsBadWrite++;
      end
      if (div0_exc) obsDiv0++;
      if (timeout_exc) begin obsTmo++; obsTmoCyc = c; end
      mult_done = !op && (c == doneCyc);
      div_done  = op && (c == doneCyc);
      abort     = (c == abortCyc);
      if (noiseOther) begin
        if (op) mult_done = 1'b1;
        else    div_done  = 1'b1;
      end
      if (noiseReq) begin
        req_valid = 1'($urandom_range(0, 1));
        req_op    = 1'($urandom_range(0, 1));
      end
      tick;
    end
    req_valid = 1'b0; mult_done = 1'b0; div_done = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset;
    req_valid = 1'b1; mult_done = 1'b1; abort = 1'b1;
    tick; tick;
    checks++;
    if (idleVec() !== {1'b1, 72'b0}) $display("[TB] FAIL reset_during got=%h want=%h", idleVec(), {1'b1, 72'b0});
    else passed++;
    reset = 1'b0; req_valid = 1'b0; mult_done = 1'b0; abort = 1'b0;
    tick;
    checks++;
    if (idleVec() !== {1'b1, 72'b0}) $display("[TB] FAIL reset_after got=%h want=%h", idleVec(), {1'b1, 72'b0});
    else passed++;
  endtask

  task automatic test_mult;
    runTxn(1'b0, 2, -1, 64'hFFFFFFFF_FFFFFFEB, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obsDone !== 1 || obsDoneCyc !== 3) $display("[TB] FAIL mult_done got=%0d@%0d want=1@3", obsDone, obsDoneCyc);
    else passed++;
    checks++;
    if ({obsHi, obsLo} !== 64'hFFFFFFFF_FFFFFFEB) $display("[TB] FAIL mult_hilo got=%h%h want=ffffffffffffffeb", obsHi, obsLo);
    else passed++;
    checks++;
    if (obsWrBoth !== 1'b1 || obsBadWrite !== 0) $display("[TB] FAIL mult_write got=%b/%0d want=1/0", obsWrBoth, obsBadWrite);
    else passed++;
    checks++;
    if (obsMultStarts !== 1 || obsDivStarts !== 0) $display("[TB] FAIL mult_starts got=%0d/%0d want=1/0", obsMultStarts, obsDivStarts);
    else passed++;
    checks++;
    if (hi_in !== 32'hFFFFFFFF || lo_in !== 32'hFFFFFFEB) $display("[TB] FAIL hilo_hold got=%h/%h want=ffffffff/ffffffeb", hi_in, lo_in);
    else passed++;
  endtask

  task automatic test_latency;
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    runTxn(1'b0, 1, -1, smul(a, b), 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obsDoneCyc !== 2 || obsReadyCyc !== 3) $display("[TB] FAIL latency got=%0d/%0d want=2/3", obsDoneCyc, obsReadyCyc);
    else passed++;
    checks++;
    if ({obsHi, obsLo} !== smul(a, b)) $display("[TB] FAIL latency_prod got=%h%h want=%h", obsHi, obsLo, smul(a, b));
    else passed++;
  endtask

  task automatic test_div;
    runTxn(1'b1, 3, -1, 64'h0123_4567_89AB_CDEF, 32'd3, 32'd2, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obsDone !== 1 || obsDoneCyc !== 4) $display("[TB] FAIL div_done got=%0d@%0d want=1@4", obsDone, obsDoneCyc);
    else passed++;
    checks++;
    if (obsHi !== 32'h2 || obsLo !== 32'h3 || obsWrBoth !== 1'b1) $display("[TB] FAIL div_hilo got=%h/%h/%b want=2/3/1", obsHi, obsLo, obsWrBoth);
    else passed++;
    checks++;
    if (obsDivStarts !== 1 || obsMultStarts !== 0 || obsDiv0 !== 0) $display("[TB] FAIL div_starts got=%0d/%0d/%0d want=1/0/0", obsDivStarts, obsMultStarts, obsDiv0);
    else passed++;
  endtask

  task automatic test_div_zero;
    runTxn(1'b1, 2, -1, 64'h0, 32'hFFFFFFFF, 32'h11, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obsDone !== 1 || obsDiv0 !== 1) $display("[TB] FAIL div0_pulse got=%0d/%0d want=1/1", obsDone, obsDiv0);
    else passed++;
    checks++;
    if (obsWrAny !== 1'b0 || obsBadWrite !== 0) $display("[TB] FAIL div0_nowrite got=%b/%0d want=0/0", obsWrAny, obsBadWrite);
    else passed++;
  endtask

  task automatic test_timeout;
    runTxn(1'b0, -1, -1, 64'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (obsTmo !== 1 || obsTmoCyc !== T + 1) $display("[TB] FAIL tmo_pulse got=%0d@%0d want=1@%0d", obsTmo, obsTmoCyc, T + 1);
    else passed++;
    checks++;
    if (obsReadyCyc !== T + 2 || obsDone !== 0 || obsBadWrite !== 0) $display("[TB] FAIL tmo_end got=%0d/%0d/%0d want=%0d/0/0", obsReadyCyc, obsDone, obsBadWrite, T + 2);
    else passed++;
    checks++;
    if (obsMultStarts !== 1 || obsDivStarts !== 0) $display("[TB] FAIL tmo_ignore_req got=%0d/%0d want=1/0", obsMultStarts, obsDivStarts);
    else passed++;
  endtask

  task automatic test_abort;
    runTxn(1'b0, 2, 2, 64'h5, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obsReadyCyc !== 3 || obsDone !== 0 || obsBadWrite !== 0) $display("[TB] FAIL abort_wait got=%0d/%0d/%0d want=3/0/0", obsReadyCyc, obsDone, obsBadWrite);
    else passed++;
    runTxn(1'b1, 1, 0, 64'h0, 32'h7, 32'h8, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obsReadyCyc !== 1 || obsDone !== 0 || obsDivStarts !== 1) $display("[TB] FAIL abort_start got=%0d/%0d/%0d want=1/0/1", obsReadyCyc, obsDone, obsDivStarts);
    else passed++;
    runTxn(1'b0, 2, 3, 64'h0000_0009_0000_000A, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obsDone !== 1 || obsLo !== 32'hA || obsReadyCyc !== 4) $display("[TB] FAIL abort_in_wb got=%0d/%h/%0d want=1/a/4", obsDone, obsLo, obsReadyCyc);
    else passed++;
  endtask

  task automatic test_reset_mid;
    mult_result = 64'h1111_2222_3333_4444;
    req_valid = 1'b1; req_op = 1'b0;
    tick;
    req_valid = 1'b0;
    tick; tick;
    reset = 1'b1; mult_done = 1'b1; abort = 1'b1; req_valid = 1'b1;
    tick;
    checks++;
    if (idleVec() !== {1'b1, 72'b0}) $display("[TB] FAIL reset_mid got=%h want=%h", idleVec(), {1'b1, 72'b0});
    else passed++;
    reset = 1'b0; mult_done = 1'b0; abort = 1'b0; req_valid = 1'b0;
    tick;
    checks++;
    if (idleVec() !== {1'b1, 72'b0}) $display("[TB] FAIL reset_mid_after got=%h want=%h", idleVec(), {1'b1, 72'b0});
    else passed++;
  endtask

  task automatic test_random;
    logic        op, dz;
    int          dc, ac;
    logic [31:0] a, b, q, r;
    logic [63:0] mres;
    bit          nO, nR;
    for (int n = 0; n < 60; n++) begin
      op = 1'($urandom_range(0, 1));
      dc = int'($urandom_range(0, 10));
      if (dc == 0) dc = -1;
      ac = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 11)) : -1;
      a = $urandom; b = $urandom; q = $urandom; r = $urandom;
      mres = smul(a, b);
      dz = ($urandom_range(0, 2) == 0);
      nO = 1'($urandom_range(0, 1));
      nR = 1'($urandom_range(0, 1));
      model(op, dc, ac, mres, q, r, dz);
      runTxn(op, dc, ac, mres, q, r, dz, nO, nR);
      checks++;
      if (obsReadyCyc !== eReady) $display("[TB] FAIL rnd%0d_ready got=%0d want=%0d", n, obsReadyCyc, eReady);
      else passed++;
      checks++;
      if (obsDoneCyc !== eDoneCyc || obsDone !== int'(eDoneCyc >= 0)) $display("[TB] FAIL rnd%0d_done got=%0d@%0d want=@%0d", n, obsDone, obsDoneCyc, eDoneCyc);
      else passed++;
      checks++;
      if (obsTmoCyc !== eTmoCyc || obsTmo !== int'(eTmoCyc >= 0)) $display("[TB] FAIL rnd%0d_tmo got=%0d@%0d want=@%0d", n, obsTmo, obsTmoCyc, eTmoCyc);
      else passed++;
      checks++;
      if (obsDiv0 !== int'(eDiv0) || obsBadWrite !== 0 || obsBadBusy !== 0) $display("[TB] FAIL rnd%0d_status got=%0d/%0d/%0d want=%0d/0/0", n, obsDiv0, obsBadWrite, obsBadBusy, eDiv0);
      else passed++;
      checks++;
      if (obsMultStarts !== int'(!op) || obsDivStarts !== int'(op) || obsBothStarts !== 0) $display("[TB] FAIL rnd%0d_starts got=%0d/%0d want=%0d/%0d", n, obsMultStarts, obsDivStarts, !op, op);
      else passed++;
      if (eDoneCyc >= 0) begin
        checks++;
        if (obsWrAny !== eWrite || obsWrBoth !== eWrite) $display("[TB] FAIL rnd%0d_write got=%b/%b want=%b", n, obsWrAny, obsWrBoth, eWrite);
        else passed++;
        checks++;
        if (obsHi !== eHi || obsLo !== eLo) $display("[TB] FAIL rnd%0d_hilo got=%h/%h want=%h/%h", n, obsHi, obsLo, eHi, eLo);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_latency();
    test_div();
    test_div_zero();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_controller.md
MULDIV_CONTROLLER -- requirements
Module: muldiv_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, giving the maximum WAIT cycles before a timeout fault (legal range 2..1024).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, the control unit requests a MULT/DIV operation.
REQ-005 SHALL have port req_op, input, 1, operation select: 0 = MULT, 1 = DIV.
REQ-006 SHALL have port req_ready, output, 1, controller idle and able to accept a request.
REQ-007 SHALL have port abort, input, 1, flush of the current operation (exception or PC redirect).
REQ-008 SHALL have ports mult_start and div_start, output, 1 each, start pulses to the multiplier and divider.
REQ-009 SHALL have ports mult_done and div_done, input, 1 each, completion flags from the multiplier and divider.
REQ-010 SHALL have port mult_result, input, 64, signed product.
REQ-011 SHALL have ports div_quotient and div_remainder, input, 32 each, divider outputs.
REQ-012 SHALL have port div_by_zero, input, 1, divider zero-divisor flag, valid with div_done.
REQ-013 SHALL have ports hi_in and lo_in, output, 32 each, write data to the HI/LO registers.
REQ-014 SHALL have ports hi_write and lo_write, output, 1 each, write enables to the HI/LO registers.
REQ-015 SHALL have ports busy, done, div0_exc and timeout_exc, output, 1 each, status and one-cycle event pulses.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, START, WAIT, WB and TMO; all outputs decode from state and latched registers only.
REQ-017 IDLE: req_ready=1 and busy=0; when req_valid=1, the FSM SHALL latch req_op into op_q and move to START.
REQ-018 START (exactly one cycle): the FSM SHALL assert mult_start if op_q=0 or div_start if op_q=1, never both, clear the wait counter, and move to WAIT.
REQ-019 WAIT: if the done flag of the selected unit is 1, the FSM SHALL latch results and move to WB; the done flag of the non-selected unit SHALL be ignored.
REQ-020 WAIT: each cycle without done SHALL increment the counter; when the counter equals TIMEOUT_CYCLES-1 with no done, the FSM SHALL move to TMO.
REQ-021 Latching on MULT: hi_q=mult_result[63:32] and lo_q=mult_result[31:0]. Latching on DIV: hi_q=div_remainder, lo_q=div_quotient, and dz_q=div_by_zero.
REQ-022 WB (one cycle): done=1; hi_in=hi_q and lo_in=lo_q; hi_write=lo_write=1 unless op_q=1 and dz_q=1, in which case both writes=0 and div0_exc=1; next state IDLE.
REQ-023 TMO (one cycle): timeout_exc=1, no HI/LO write, done=0; next state IDLE.
REQ-024 busy SHALL be 1 in START, WAIT, WB and TMO; req_ready SHALL be the inverse of busy; req_valid while busy SHALL be ignored and not queued.
REQ-025 abort=1 in START or WAIT SHALL force IDLE at the next edge with no HI/LO write and no event pulse; abort SHALL win over a simultaneous done or timeout.
REQ-026 abort in IDLE, WB or TMO SHALL have no effect; WB/TMO SHALL complete normally.
REQ-027 Latency: with the request accepted at edge k and done seen in the first WAIT cycle, the done pulse SHALL occur in cycle k+3 and req_ready SHALL return at k+4.
REQ-028 hi_in and lo_in SHALL hold their latched value outside WB; consumers SHALL rely only on the write enables.

Reset
REQ-029 reset=1 SHALL at the next edge force IDLE, op_q=0, dz_q=0, counter=0, and hi_q=lo_q=0, regardless of state, including mid-operation.
REQ-030 During and after reset, all outputs SHALL be 0 except req_ready=1.
REQ-031 reset SHALL take priority over abort, req_valid and done.

Verification
REQ-032 MULT with mult_result=64'hFFFFFFFF_FFFFFFEB (7*-3) and done 2 cycles after the start pulse -> a single WB cycle with hi_in=FFFFFFFF, lo_in=FFFFFFEB, hi_write=lo_write=done=1; mult_start pulsed exactly once; div_start never asserted.
REQ-033 DIV with quotient 3, remainder 2 (17/5) -> hi_in=00000002 and lo_in=00000003 written; mult_done=1 pulsed during WAIT is ignored.
REQ-034 DIV with div_by_zero=1 and div_done=1 -> WB with done=1, div0_exc=1 and hi_write=lo_write=0.
REQ-035 TIMEOUT_CYCLES=8 with done never asserted -> timeout_exc=1 for one cycle exactly 8 WAIT cycles after START, then req_ready=1; a req_valid during the wait is ignored.
REQ-036 abort and mult_done asserted in the same WAIT cycle -> IDLE next cycle, no write, no done; reset asserted in WAIT -> IDLE next cycle with req_ready=1 and all pulses 0.
